// File: rtl/multicycle_control.sv
// Moore control FSM for a shared-datapath multicycle MIPS core: sequences
// fetch/decode/execute, counts retired instructions and flags bad opcodes.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t           r_state;
  state_t           w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;
  logic             w_retire;
  logic             w_bad_op;

  // Memory handshake: mem_read/mem_write is a request held high until the
  // cycle mem_ready=1, which completes the access; mem_ready is ignored elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RESET;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_next;
      r_illegal <= (r_state == S_DECODE) && w_bad_op;
      if (w_retire) r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    w_next     = S_FETCH;
    w_retire   = 1'b0;
    w_bad_op   = 1'b0;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        w_next    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_R:         w_next = S_R_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EXEC;
          default: begin
            w_next   = S_FETCH;
            w_bad_op = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        w_next   = mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_retire   = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        w_next    = mem_ready ? S_FETCH : S_MEM_WR;
        w_retire  = mem_ready;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_retire  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_write  = zero;
        w_retire  = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        w_retire = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        w_retire  = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign illegal_op  = r_illegal;
  assign state       = r_state;
  assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by
// cycle against hand-written control vectors; a CNT_W=4 copy checks wrap.
module tb_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;

  logic        pc_write, ir_write, iord, mem_read, mem_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  logic        pc_write4, ir_write4, iord4, mem_read4, mem_write4;
  logic        reg_write4, reg_dst4, mem_to_reg4, alu_src_a4, illegal_op4;
  logic [1:0]  pc_src4, alu_src_b4, alu_op4;
  logic [3:0]  state4;
  logic [3:0]  instr_count4;

  int          n_checks;
  int          n_errors;
  logic [31:0] exp_cnt;
  logic [15:0] ctrl;

  // {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
  //  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op}
  localparam logic [15:0] C_ZERO      = 16'b0_00_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [15:0] C_FETCH_W   = 16'b0_00_0_0_1_0_0_0_0_0_01_00_0;
  localparam logic [15:0] C_FETCH     = 16'b1_00_1_0_1_0_0_0_0_0_01_00_0;
  localparam logic [15:0] C_FETCH_ILL = 16'b1_00_1_0_1_0_0_0_0_0_01_00_1;
  localparam logic [15:0] C_DECODE    = 16'b0_00_0_0_0_0_0_0_0_0_11_00_0;
  localparam logic [15:0] C_MEM_ADDR  = 16'b0_00_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [15:0] C_MEM_RD    = 16'b0_00_0_1_1_0_0_0_0_0_00_00_0;
  localparam logic [15:0] C_MEM_WB    = 16'b0_00_0_0_0_0_1_0_1_0_00_00_0;
  localparam logic [15:0] C_MEM_WR    = 16'b0_00_0_1_0_1_0_0_0_0_00_00_0;
  localparam logic [15:0] C_R_EXEC    = 16'b0_00_0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [15:0] C_R_WB      = 16'b0_00_0_0_0_0_1_1_0_0_00_00_0;
  localparam logic [15:0] C_BR_T      = 16'b1_01_0_0_0_0_0_0_0_1_00_01_0;
  localparam logic [15:0] C_BR_N      = 16'b0_01_0_0_0_0_0_0_0_1_00_01_0;
  localparam logic [15:0] C_JUMP      = 16'b1_10_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [15:0] C_ADDI_EXEC = 16'b0_00_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [15:0] C_ADDI_WB   = 16'b0_00_0_0_0_0_1_0_0_0_00_00_0;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  assign ctrl = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op};

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_op(illegal_op),
    .state(state), .instr_count(instr_count)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write4), .pc_src(pc_src4), .ir_write(ir_write4), .iord(iord4),
    .mem_read(mem_read4), .mem_write(mem_write4), .reg_write(reg_write4),
    .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4), .alu_src_a(alu_src_a4),
    .alu_src_b(alu_src_b4), .alu_op(alu_op4), .illegal_op(illegal_op4),
    .state(state4), .instr_count(instr_count4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs just after the edge, then check the settled outputs.
  task automatic cyc(input logic mr, input logic z, input logic [5:0] op,
                     input logic [3:0] st, input logic [15:0] exp_ctrl);
    @(posedge clk);
    #1;
    mem_ready = mr;
    zero      = z;
    opcode    = op;
    #1;
    check("state", {28'd0, state}, {28'd0, st});
    check("ctrl", {16'd0, ctrl}, {16'd0, exp_ctrl});
    check("count", instr_count, exp_cnt);
    check("state4", {28'd0, state4}, {28'd0, st});
    check("count4", {28'd0, instr_count4}, {28'd0, exp_cnt[3:0]});
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_cnt   = 0;
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = OP_R;
    zero      = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_ctrl", {16'd0, ctrl}, 32'd0);
    check("rst_count", instr_count, 32'd0);
    rst_n = 1'b1;

    // R-type: 1,2,7,8 then back to FETCH
    cyc(1, 0, OP_R, 4'd1, C_FETCH);
    cyc(1, 0, OP_R, 4'd2, C_DECODE);
    cyc(1, 0, OP_R, 4'd7, C_R_EXEC);
    cyc(1, 0, OP_R, 4'd8, C_R_WB);
    exp_cnt = exp_cnt + 1;

    // lw with 2 fetch stalls and 3 read stalls: 10 cycles
    cyc(0, 0, OP_LW, 4'd1, C_FETCH_W);
    cyc(0, 0, OP_LW, 4'd1, C_FETCH_W);
    cyc(1, 0, OP_LW, 4'd1, C_FETCH);
    cyc(1, 0, OP_LW, 4'd2, C_DECODE);
    cyc(1, 0, OP_LW, 4'd3, C_MEM_ADDR);
    cyc(0, 0, OP_LW, 4'd4, C_MEM_RD);
    cyc(0, 0, OP_LW, 4'd4, C_MEM_RD);
    cyc(0, 0, OP_LW, 4'd4, C_MEM_RD);
    cyc(1, 0, OP_LW, 4'd4, C_MEM_RD);
    cyc(1, 0, OP_LW, 4'd5, C_MEM_WB);
    exp_cnt = exp_cnt + 1;

    // beq taken then not taken
    cyc(1, 1, OP_BEQ, 4'd1, C_FETCH);
    cyc(1, 1, OP_BEQ, 4'd2, C_DECODE);
    cyc(1, 1, OP_BEQ, 4'd9, C_BR_T);
    exp_cnt = exp_cnt + 1;
    cyc(1, 0, OP_BEQ, 4'd1, C_FETCH);
    cyc(1, 0, OP_BEQ, 4'd2, C_DECODE);
    cyc(1, 0, OP_BEQ, 4'd9, C_BR_N);
    exp_cnt = exp_cnt + 1;

    // j, then an illegal opcode that must not retire
    cyc(1, 0, OP_J, 4'd1, C_FETCH);
    cyc(1, 0, OP_J, 4'd2, C_DECODE);
    cyc(1, 0, OP_J, 4'd10, C_JUMP);
    exp_cnt = exp_cnt + 1;
    cyc(1, 0, OP_BAD, 4'd1, C_FETCH);
    cyc(1, 0, OP_BAD, 4'd2, C_DECODE);
    cyc(1, 0, OP_SW, 4'd1, C_FETCH_ILL);

    // sw fetched in the illegal-flag cycle; pulse must be gone in DECODE
    cyc(1, 0, OP_SW, 4'd2, C_DECODE);
    cyc(1, 0, OP_SW, 4'd3, C_MEM_ADDR);
    cyc(1, 0, OP_SW, 4'd6, C_MEM_WR);
    exp_cnt = exp_cnt + 1;

    // sw stalled in MEM_WR, then async reset mid-cycle
    cyc(1, 0, OP_SW, 4'd1, C_FETCH);
    cyc(1, 0, OP_SW, 4'd2, C_DECODE);
    cyc(1, 0, OP_SW, 4'd3, C_MEM_ADDR);
    cyc(0, 0, OP_SW, 4'd6, C_MEM_WR);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", {28'd0, state}, 32'd0);
    check("arst_ctrl", {16'd0, ctrl}, 32'd0);
    check("arst_count", instr_count, 32'd0);
    check("arst_count4", {28'd0, instr_count4}, 32'd0);
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 17 addi: the 4-bit counter goes 15 -> 0 -> 1
    for (int i = 0; i < 17; i++) begin
      cyc(1, 0, OP_ADDI, 4'd1, C_FETCH);
      cyc(1, 0, OP_ADDI, 4'd2, C_DECODE);
      cyc(1, 0, OP_ADDI, 4'd11, C_ADDI_EXEC);
      cyc(1, 0, OP_ADDI, 4'd12, C_ADDI_WB);
      exp_cnt = exp_cnt + 1;
      if (i == 14) begin
        @(posedge clk);
        #2;
        check("cnt4_at_15", {28'd0, instr_count4}, 32'd15);
        check("cnt_at_15", instr_count, 32'd15);
        // that extra edge was the FETCH of the next addi
        cyc(1, 0, OP_ADDI, 4'd2, C_DECODE);
        cyc(1, 0, OP_ADDI, 4'd11, C_ADDI_EXEC);
        cyc(1, 0, OP_ADDI, 4'd12, C_ADDI_WB);
        exp_cnt = exp_cnt + 1;
        i++;
      end
    end
    cyc(1, 0, OP_ADDI, 4'd1, C_FETCH);
    check("cnt4_final", {28'd0, instr_count4}, 32'd1);
    check("cnt_final", instr_count, 32'd17);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences the shared multicycle MIPS datapath: PC, instruction register, single ALU, muxes, sign-extend/shift-left-2 and jump-address path.
- Decodes the opcode, drives every mux select and write enable, and handshakes with a memory port that may stall.
- Also counts retired instructions and flags unsupported opcodes.

Parameters:
- CNT_W, 32, width of retired-instruction counter instr_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  IR[31:26].
- zero  input  1  ALU zero flag, sampled only in BRANCH.
- mem_ready  input  1  memory completes current read/write this cycle.
- pc_write  output  1  load PC.
- pc_src  output  2  00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target.
- ir_write  output  1  load IR.
- iord  output  1  memory address: 0 PC, 1 ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- reg_write  output  1  register file write.
- reg_dst  output  1  0 rt, 1 rd.
- mem_to_reg  output  1  0 ALUOut, 1 MDR.
- alu_src_a  output  1  0 PC, 1 reg A.
- alu_src_b  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- alu_op  output  2  00 add, 01 sub, 10 by funct.
- illegal_op  output  1  one-cycle pulse on unsupported opcode.
- state  output  4  current state code, for debug.
- instr_count  output  CNT_W  retired instructions.

Behaviour:
- State register and counter are async reset on rst_n low. State goes to RESET(0), instr_count=0, illegal_op=0.
- All control outputs are pure decodes of state (plus mem_ready/zero where noted), so they are 0 in RESET. Reset mid-instruction aborts it immediately; no partial writes.
- Any output not listed for a state is 0.
- RESET(0): outputs 0. Next state FETCH.
- FETCH(1): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write=pc_write=mem_ready. Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE(2): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 100011 or 101011 -> MEM_ADDR.
  - 000000 -> R_EXEC.
  - 000100 -> BRANCH.
  - 000010 -> JUMP.
  - 001000 -> ADDI_EXEC.
  - Other -> FETCH, with illegal_op registered high for exactly the next cycle.
- MEM_ADDR(3): alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEM_RD if opcode=100011, else MEM_WR.
- MEM_RD(4): mem_read=1, iord=1. Holds until mem_ready, then MEM_WB.
- MEM_WB(5): reg_write=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- MEM_WR(6): mem_write=1, iord=1. Holds until mem_ready, then FETCH.
- R_EXEC(7): alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB(8): reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- BRANCH(9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=zero. Next state FETCH.
- JUMP(10): pc_src=10, pc_write=1. Next state FETCH.
- ADDI_EXEC(11): alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDI_WB.
- ADDI_WB(12): reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- Codes 13-15 are unreachable; if entered, outputs are 0 and next state is FETCH.
- opcode is assumed stable from IR after FETCH; the FSM does not latch it.
- mem_ready is ignored in states without a memory request.
- mem_read and mem_write are never both 1.
- instr_count increments by 1, wrapping at 2^CNT_W, on each transition into FETCH from:
  - MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB;
  - MEM_WR with mem_ready=1.
  It does not increment on the illegal-opcode path or on RESET->FETCH.
- Cycle counts with mem_ready tied high: lw 5, sw/R/addi 4, beq/j 3.

Test Plan:
- Hold rst_n=0 for 3 cycles, then release with mem_ready=1 and opcode=000000 -> state goes 0,1,2,7,8,1. reg_write=1 and reg_dst=1 only in state 8. instr_count=1 on re-entering FETCH.
- lw (100011) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD:
  - ir_write/pc_write are 1 only in the single FETCH cycle with mem_ready=1.
  - mem_read/iord=1 held in MEM_RD for 4 cycles.
  - MEM_WB asserts mem_to_reg=1.
  - Total 10 cycles.
- beq (000100): run once with zero=1, once with zero=0 -> in BRANCH pc_src=01 both times; pc_write=1 and 0 respectively. Both runs take 3 cycles and both increment instr_count.
- j (000010) then opcode 111111 -> JUMP asserts pc_src=10 and pc_write=1. Illegal path: DECODE->FETCH, illegal_op=1 for exactly one cycle, instr_count unchanged.
- Set CNT_W=4 and run 17 addi -> instr_count reaches 15, then wraps to 0, then 1.
- Assert rst_n=0 mid-cycle while in MEM_WR with mem_ready=0 -> state=0 and all outputs 0 immediately (asynchronously), instr_count=0. After release, next state is FETCH.
